// File: rtl/axis_dst_framer_if.sv
// axis_dst_framer_if: result stream into the framer and AXI4-Stream out of it
// master: framer side (takes s_*, drives M_AXIS_* except TREADY)
// slave:  environment side (drives s_valid/s_data and M_AXIS_TREADY)
interface axis_dst_framer_if #(
  parameter int DATA_W = 64
);
  logic s_valid;
  logic s_ready;
  logic [DATA_W-1:0] s_data;
  logic M_AXIS_TVALID;
  logic M_AXIS_TREADY;
  logic M_AXIS_TLAST;
  logic [DATA_W-1:0] M_AXIS_TDATA;
  logic [DATA_W/8-1:0] M_AXIS_TSTRB;
  modport master (
    input  s_valid, s_data, M_AXIS_TREADY,
    output s_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
  );
  modport slave (
    output s_valid, s_data, M_AXIS_TREADY,
    input  s_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
  );
endinterface

// File: rtl/axis_dst_framer.sv
// axis_dst_framer: buffers result beats in a FIFO and frames them with TLAST
// AXIS_ACLK/AXIS_ARESETN: clock, async active-low reset
// start/frame_len: begin a frame of frame_len beats (0 = unbounded)
// bus: result stream in (s_*), AXI4-Stream out (M_AXIS_*)
// busy: frame in progress incl. drain; frame_done: one-cycle completion pulse
module axis_dst_framer #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic AXIS_ACLK,
  input  logic AXIS_ARESETN,
  input  logic start,
  input  logic [LEN_W-1:0] frame_len,
  axis_dst_framer_if.master bus,
  output logic busy,
  output logic frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LEN_W-1:0] len_r, in_cnt, out_cnt;
  logic full, empty, push, pop, bounded, in_last;
  // pointers differ only in the wrap bit when every slot is occupied
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign bounded = len_r != '0;
  assign push = bus.s_valid & bus.s_ready;
  assign pop = bus.M_AXIS_TVALID & bus.M_AXIS_TREADY;
  assign in_last = bounded & (in_cnt + LEN_W'(1) == len_r);
  assign bus.M_AXIS_TVALID = ~empty;
  assign bus.M_AXIS_TDATA = mem[rd_ptr[AW-1:0]];
  assign bus.M_AXIS_TSTRB = {(DATA_W/8){bus.M_AXIS_TVALID}};
  assign bus.M_AXIS_TLAST = bus.M_AXIS_TVALID & bounded & (out_cnt == len_r - LEN_W'(1));
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    frame_done = 1'b0;
    bus.s_ready = 1'b0;
    case (state)
      IDLE: state_nx = start ? RUN : IDLE;
      RUN: begin
        bus.s_ready = ~full & (~bounded | (in_cnt != len_r));
        state_nx = (push & in_last) ? DRAIN : RUN;
      end
      DRAIN: begin
        frame_done = (out_cnt == len_r) & empty;
        state_nx = frame_done ? IDLE : DRAIN;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN)
    if (!AXIS_ARESETN) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len_r <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
    end else begin
      state <= state_nx;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      if (state == IDLE && start) begin
        len_r <= frame_len;
        in_cnt <= '0;
        out_cnt <= '0;
      end else begin
        in_cnt <= in_cnt + LEN_W'(push);
        // out_cnt parks at len_r in bounded frames; free-runs when unbounded
        if (pop && (!bounded || out_cnt != len_r)) out_cnt <= out_cnt + LEN_W'(1);
      end
    end
  always_ff @(posedge AXIS_ACLK)
    if (push) mem[wr_ptr[AW-1:0]] <= bus.s_data;
endmodule

// File: tb/tb_axis_dst_framer.sv
// tb_axis_dst_framer: directed vector table plus multi-cycle framing sequences
module tb_axis_dst_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] frame_len = '0;
  logic busy, frame_done;
  int total = 0;
  int bad = 0;
  axis_dst_framer_if #(.DATA_W(64)) bus ();
  axis_dst_framer #(.DATA_W(64), .DEPTH(4), .LEN_W(16)) dut (
    .AXIS_ACLK(clk),
    .AXIS_ARESETN(rst_n),
    .start(start),
    .frame_len(frame_len),
    .bus(bus),
    .busy(busy),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st;
    logic [15:0] len;
    logic sv;
    logic [63:0] sd;
    logic tr;
    logic rdy, tv, tl, bz, dn;
    logic [63:0] td;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic st, logic [15:0] len, logic sv, logic [63:0] sd, logic tr,
                             logic rdy, logic tv, logic [63:0] td, logic tl, logic bz, logic dn);
    vec_t r;
    r.st = st; r.len = len; r.sv = sv; r.sd = sd; r.tr = tr;
    r.rdy = rdy; r.tv = tv; r.td = td; r.tl = tl; r.bz = bz; r.dn = dn;
    return r;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic seq(string nm, int len, int offer, int pv, int pr, int hold, int budget,
                     logic [63:0] base, int exp_beats, int exp_done);
    int nin, nout, ndone, extra;
    nin = 0; nout = 0; ndone = 0; extra = 0;
    @(posedge clk); #1;
    start = 1'b1; frame_len = 16'(len); bus.s_valid = 1'b0; bus.M_AXIS_TREADY = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (hold > 0 && cyc == hold) chk({nm, " filled"}, 64'(nin), 64'(len < 4 ? len : 4));
      bus.s_valid = (nin < offer) && ($urandom_range(99) < pv);
      bus.s_data = base + 64'(nin);
      bus.M_AXIS_TREADY = (cyc >= hold) && ($urandom_range(99) < pr);
      @(negedge clk);
      if (bus.M_AXIS_TVALID) begin
        chk({nm, " tdata"}, bus.M_AXIS_TDATA, base + 64'(nout));
        chk({nm, " tlast"}, 64'(bus.M_AXIS_TLAST), 64'(len != 0 && nout == len - 1));
      end
      if (nin - nout >= 4) chk({nm, " full_ready"}, 64'(bus.s_ready), 64'd0);
      if (len != 0 && nin >= len) chk({nm, " excess_ready"}, 64'(bus.s_ready), 64'd0);
      if (len == 0) chk({nm, " busy"}, 64'(busy), 64'd1);
      if (frame_done) begin
        ndone++;
        chk({nm, " done_beats"}, 64'(nout), 64'(len));
      end
      if (bus.s_valid && bus.s_ready) nin++;
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) nout++;
      @(posedge clk); #1;
      if (ndone > 0) extra++;
      if (extra > 3 || (len == 0 && nout >= offer)) break;
    end
    bus.s_valid = 1'b0;
    chk({nm, " in_beats"}, 64'(nin), 64'(exp_beats));
    chk({nm, " out_beats"}, 64'(nout), 64'(exp_beats));
    chk({nm, " done_count"}, 64'(ndone), 64'(exp_done));
    chk({nm, " busy_end"}, 64'(busy), 64'(len == 0));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.M_AXIS_TREADY = 1'b0;
    // basic frame of 4
    tbl.push_back(v(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 2, 1, 1, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 3, 1, 1, 1, 2, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 4, 1, 1, 1, 3, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 4, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // frame of 2 with excess input held valid
    tbl.push_back(v(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 'hA1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 'hA2, 1, 1, 1, 'hA1, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 'hA3, 1, 0, 1, 'hA2, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, 'hA3, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 1, 'hA3, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // one-beat frame, stalled output, start ignored while draining
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 'hB1, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 5, 1, 'hB2, 0, 0, 1, 'hB1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 'hB1, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {bus.s_ready, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST, busy, frame_done}, 5'b0);
    chk("reset tstrb", 64'(bus.M_AXIS_TSTRB), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      start = tbl[i].st;
      frame_len = tbl[i].len;
      bus.s_valid = tbl[i].sv;
      bus.s_data = tbl[i].sd;
      bus.M_AXIS_TREADY = tbl[i].tr;
      @(negedge clk);
      chk($sformatf("vec%0d flags", i),
          {bus.s_ready, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST, busy, frame_done},
          {tbl[i].rdy, tbl[i].tv, tbl[i].tl, tbl[i].bz, tbl[i].dn});
      chk($sformatf("vec%0d tstrb", i), 64'(bus.M_AXIS_TSTRB), tbl[i].tv ? 64'hFF : 64'h0);
      if (tbl[i].tv) chk($sformatf("vec%0d tdata", i), bus.M_AXIS_TDATA, tbl[i].td);
    end
    @(posedge clk); #1;
    start = 1'b0;
    bus.s_valid = 1'b0;
    seq("backpressure", 8, 8, 100, 100, 10, 200, 64'h100, 8, 1);
    seq("unbounded", 0, 300, 80, 90, 0, 2000, 64'h1000, 300, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // reset mid-frame: three beats buffered behind a stalled output
    @(posedge clk); #1;
    start = 1'b1; frame_len = 16'd6; bus.M_AXIS_TREADY = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = 64'hC0 + 64'(i);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset tvalid", 64'(bus.M_AXIS_TVALID), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset flags", {bus.s_ready, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST, busy, frame_done}, 5'b0);
    chk("async reset tstrb", 64'(bus.M_AXIS_TSTRB), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seq("after_reset_len1", 1, 3, 100, 100, 0, 50, 64'hD0, 1, 1);
    seq("random_1000", 1000, 1000, 70, 60, 0, 10000, 64'h5000_0000, 1000, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
